// File: rtl/axilite_regfile_slave.sv
// rtl/axilite_regfile_slave.sv - AXI4-lite slave register file with byte strobes and write pulses
module axilite_regfile_slave #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    input  logic [31:0]              s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_HAVE_AW = 2'd1;
    localparam logic [1:0] W_HAVE_W  = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]  wstate;
    logic        rstate;
    logic        up;
    logic [29:0] aw_idx_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] regs [NUM_REGS];

    logic        aw_hs, w_hs, ar_hs;
    logic        commit;
    logic [29:0] c_idx;
    logic [31:0] c_data;
    logic [3:0]  c_strb;
    logic        c_in_range;
    logic [29:0] ar_idx;
    logic        ar_in_range;
    logic [31:0] rd_word;

    // Protection bits and byte-offset low bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_awready = up & ((wstate == W_IDLE) | (wstate == W_HAVE_W));
    assign s_axi_wready  = up & ((wstate == W_IDLE) | (wstate == W_HAVE_AW));
    assign s_axi_bvalid  = (wstate == W_RESP);
    assign s_axi_arready = up & (rstate == R_IDLE);
    assign s_axi_rvalid  = (rstate == R_DATA);

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // Select the address/data halves of the write that completes on this edge.
    always_comb begin
        commit = 1'b0;
        c_idx  = s_axi_awaddr[31:2];
        c_data = s_axi_wdata;
        c_strb = s_axi_wstrb;
        case (wstate)
            W_IDLE:    commit = aw_hs & w_hs;
            W_HAVE_AW: begin
                commit = w_hs;
                c_idx  = aw_idx_q;
            end
            W_HAVE_W:  begin
                commit = aw_hs;
                c_data = w_data_q;
                c_strb = w_strb_q;
            end
            default:   commit = 1'b0;
        endcase
    end

    assign c_in_range  = (c_idx < 30'(NUM_REGS));
    assign ar_idx      = s_axi_araddr[31:2];
    assign ar_in_range = (ar_idx < 30'(NUM_REGS));

    // Read mux over the current (pre-commit) register contents.
    always_comb begin
        rd_word = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == 30'(i)) rd_word = regs[i];
        end
    end

    // Write channel FSM; 'up' holds readies low for the cycle following reset.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wstate      <= W_IDLE;
            up          <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
            aw_idx_q    <= 30'h0;
            w_data_q    <= 32'h0;
            w_strb_q    <= 4'h0;
        end else begin
            up <= 1'b1;
            if (commit) begin
                wstate      <= W_RESP;
                s_axi_bresp <= c_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                case (wstate)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wstate   <= W_HAVE_AW;
                            aw_idx_q <= s_axi_awaddr[31:2];
                        end else if (w_hs) begin
                            wstate   <= W_HAVE_W;
                            w_data_q <= s_axi_wdata;
                            w_strb_q <= s_axi_wstrb;
                        end
                    end
                    W_RESP:  if (s_axi_bready) wstate <= W_IDLE;
                    default: wstate <= wstate;
                endcase
            end
        end
    end

    // Register storage: byte-lane update and one-cycle write pulse on an in-range commit.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr_pulse[i] <= commit & c_in_range & (c_idx == 30'(i));
                if (commit && c_in_range && (c_idx == 30'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read channel FSM; data and response captured on the AR handshake edge.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rstate      <= R_IDLE;
            s_axi_rdata <= 32'h0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rstate      <= R_DATA;
                    s_axi_rdata <= ar_in_range ? rd_word : 32'h0;
                    s_axi_rresp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                end
                default: if (s_axi_rready) rstate <= R_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule
